param_stack: RTL and testbench
==============================

// Module: param_stack
// PURPOSE
//   Parametrised LIFO stack, successor to the fixed 16-bit/32-entry stack.
//   Generic data width and depth; full/empty flags; sticky overflow/underflow
//   error flags; push+pop replace-top and swap-top-two operations. Used as the
//   operand stack of the datapath; exposes the top two entries every cycle.
// PARAMETERS
//   WIDTH  16  data word width in bits
//   DEPTH  32  number of entries (>=2, any integer, not only powers of 2)
//   CNT_W  8   counter port width; must be >= $clog2(DEPTH+1)
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst        in   1      asynchronous, active-low reset
//   push       in   1      push val (see op table)
//   pop        in   1      pop top entry (see op table)
//   swap       in   1      exchange top and next
//   clear_err  in   1      clear sticky overflow/underflow
//   val        in   WIDTH  data to push
//   top        out  WIDTH  entry at depth 1; 0 when count==0
//   next       out  WIDTH  entry at depth 2; 0 when count<2
//   counter    out  CNT_W  number of valid entries, 0..DEPTH, zero-extended
//   full       out  1      counter==DEPTH
//   empty      out  1      counter==0
//   overflow   out  1      sticky: a push was dropped
//   underflow  out  1      sticky: a pop/swap was rejected
// BEHAVIOUR
//   Reset (rst low, async): counter=0, overflow=0, underflow=0, empty=1,
//     full=0, top=0, next=0. Storage array is not reset; top/next are masked
//     to 0 by count. Reset mid-operation discards all contents.
//   Storage: mem[0..DEPTH-1]; mem[counter-1] is top, mem[counter-2] is next.
//   top/next/full/empty are combinational from counter and mem: the effect of
//     an op sampled at edge N is visible on outputs right after edge N.
//   Op table, evaluated at each rising edge (c = counter before the edge):
//     push&pop, c>=1     : mem[c-1]<=val; counter unchanged (replace top)
//     push&pop, c==0     : behaves as push; counter<=1; no underflow
//     push only, c<DEPTH : mem[c]<=val; counter<=c+1
//     push only, c==DEPTH: no write, counter unchanged; overflow<=1
//     pop only, c>=1     : counter<=c-1 (data left in mem, unused)
//     pop only, c==0     : no change; underflow<=1
//     swap, no push/pop  : c>=2: mem[c-1]<=mem[c-2], mem[c-2]<=mem[c-1];
//                          c<2: no change; underflow<=1
//     swap with push/pop : swap ignored; push/pop row applies
//     no op              : hold
//   push&pop at c==DEPTH is a replace: no overflow.
//   Sticky flags: once set, hold until clear_err or reset. clear_err at the
//     same edge as a new error event: the error wins (flag ends 1).
//   Arithmetic: counter never wraps; saturates logically at 0 and DEPTH.
//     Internal pointer width $clog2(DEPTH+1); for non-power-of-2 DEPTH no
//     address beyond DEPTH-1 is ever written.
// TESTING
//   1 Reset, then push 0x1111,0x2222,0x3333 -> counter=3, top=0x3333,
//     next=0x2222, empty=0, full=0.
//   2 From 1: push&pop with val=0xAAAA -> counter=3, top=0xAAAA,
//     next=0x2222; then swap -> top=0x2222, next=0xAAAA.
//   3 Push DEPTH=32 words 0..31, then push 0xBEEF -> full=1, counter=32,
//     top=31, overflow=1; clear_err -> overflow=0, contents unchanged.
//   4 Empty stack: pop -> counter=0, underflow=1, top=0; push&pop val=0x5 ->
//     counter=1, top=0x5; swap -> no change, underflow stays 1.
//   5 Pop a 2-entry stack to empty -> top=0, next=0, empty=1; assert rst low
//     mid-cycle with 5 entries -> counter=0 immediately (before next edge).
//   6 Re-run 1-4 with WIDTH=8, DEPTH=5, CNT_W=3: full after 5 pushes,
//     6th push sets overflow, counter reads 3'd5.

Source files
------------

// File: rtl/param_stack_if.sv
// rtl/param_stack_if.sv - operation/status bundle of the parametrised operand stack
interface param_stack_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             push;
  logic             pop;
  logic             swap;
  logic             clear_err;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CNT_W-1:0] counter;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, swap, clear_err, val,
    input  top, next, counter, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, swap, clear_err, val,
    output top, next, counter, full, empty, overflow, underflow
  );
endinterface

// File: rtl/param_stack.sv
// rtl/param_stack.sv - parametrised LIFO operand stack with replace/swap and sticky errors
// Top two entries are read combinationally from the array, masked to 0 by the entry count.
module param_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  param_stack_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO      = PTR_W'(2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] cnt;
  logic [PTR_W-1:0] cnt_nxt;
  logic             ovf;
  logic             unf;
  logic             ovf_evt;
  logic             unf_evt;

  logic             has_one;
  logic             has_two;
  logic             is_full;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    next_addr;
  logic [WIDTH-1:0] top_raw;
  logic [WIDTH-1:0] next_raw;

  logic             wr_a_en;
  logic [AW-1:0]    wr_a_addr;
  logic [WIDTH-1:0] wr_a_data;
  logic             wr_b_en;
  logic [AW-1:0]    wr_b_addr;
  logic [WIDTH-1:0] wr_b_data;

  assign has_one = (cnt != '0);
  assign has_two = (cnt >= TWO);
  assign is_full = (cnt == CNT_FULL);

  // Addresses are forced to 0 when unused so no read ever leaves mem[0..DEPTH-1].
  assign top_addr  = has_one ? AW'(cnt - ONE) : '0;
  assign next_addr = has_two ? AW'(cnt - TWO) : '0;
  assign top_raw   = mem[top_addr];
  assign next_raw  = mem[next_addr];

  always_comb begin
    cnt_nxt   = cnt;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    wr_a_en   = 1'b0;
    wr_a_addr = top_addr;
    wr_a_data = bus.val;
    wr_b_en   = 1'b0;
    wr_b_addr = next_addr;
    wr_b_data = top_raw;

    if (bus.push && bus.pop) begin
      wr_a_en = 1'b1;
      if (!has_one) begin
        wr_a_addr = '0;
        cnt_nxt   = ONE;
      end
    end else if (bus.push) begin
      if (is_full) begin
        ovf_evt = 1'b1;
      end else begin
        wr_a_en   = 1'b1;
        wr_a_addr = AW'(cnt);
        cnt_nxt   = cnt + ONE;
      end
    end else if (bus.pop) begin
      if (has_one) begin
        cnt_nxt = cnt - ONE;
      end else begin
        unf_evt = 1'b1;
      end
    end else if (bus.swap) begin
      if (has_two) begin
        wr_a_en   = 1'b1;
        wr_a_data = next_raw;
        wr_b_en   = 1'b1;
      end else begin
        unf_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      // A new error event beats a simultaneous clear.
      ovf <= ovf_evt | (ovf & ~bus.clear_err);
      unf <= unf_evt | (unf & ~bus.clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a_en) begin
      mem[wr_a_addr] <= wr_a_data;
    end
    if (wr_b_en) begin
      mem[wr_b_addr] <= wr_b_data;
    end
  end

  assign bus.top       = has_one ? top_raw : '0;
  assign bus.next      = has_two ? next_raw : '0;
  assign bus.counter   = CNT_W'(cnt);
  assign bus.full      = is_full;
  assign bus.empty     = ~has_one;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - directed and random checks of param_stack in two configurations
module tb_param_stack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_stack_if #(.WIDTH(16), .CNT_W(8)) bus0 ();
  param_stack_if #(.WIDTH(8),  .CNT_W(3)) bus1 ();

  param_stack #(.WIDTH(16), .DEPTH(32), .CNT_W(8)) u_big   (.clk(clk), .rst(rst), .bus(bus0));
  param_stack #(.WIDTH(8),  .DEPTH(5),  .CNT_W(3)) u_small (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference: array-backed stack with an entry count per configuration.
  int unsigned m_stk [2][32];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  int          m_depth [2] = '{32, 5};
  int unsigned m_mask  [2] = '{32'hFFFF, 32'hFF};

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_top(input int id);
    return (id == 0) ? 32'(bus0.top) : 32'(bus1.top);
  endfunction
  function automatic logic [31:0] dut_next(input int id);
    return (id == 0) ? 32'(bus0.next) : 32'(bus1.next);
  endfunction
  function automatic logic [31:0] dut_cnt(input int id);
    return (id == 0) ? 32'(bus0.counter) : 32'(bus1.counter);
  endfunction
  function automatic logic [31:0] dut_flags(input int id);
    if (id == 0) return {28'd0, bus0.full, bus0.empty, bus0.overflow, bus0.underflow};
    return {28'd0, bus1.full, bus1.empty, bus1.overflow, bus1.underflow};
  endfunction

  function automatic int unsigned m_top(input int id);
    return (m_cnt[id] >= 1) ? m_stk[id][m_cnt[id]-1] : 0;
  endfunction
  function automatic int unsigned m_next(input int id);
    return (m_cnt[id] >= 2) ? m_stk[id][m_cnt[id]-2] : 0;
  endfunction

  task automatic check_dut(input int id, input string tag);
    logic [31:0] flags;
    flags = {28'd0, (m_cnt[id] == m_depth[id]), (m_cnt[id] == 0), m_ovf[id], m_unf[id]};
    expect_eq({tag, ".top"},   dut_top(id),   m_top(id));
    expect_eq({tag, ".next"},  dut_next(id),  m_next(id));
    expect_eq({tag, ".count"}, dut_cnt(id),   32'(m_cnt[id]));
    expect_eq({tag, ".flags"}, dut_flags(id), flags);
  endtask

  task automatic model_op(input int id, input bit ps, input bit pp, input bit sw,
                          input bit clr, input int unsigned v);
    int c;
    bit oe;
    bit ue;
    int unsigned tmp;
    c  = m_cnt[id];
    oe = 1'b0;
    ue = 1'b0;
    v  = v & m_mask[id];
    if (ps && pp) begin
      if (c >= 1) m_stk[id][c-1] = v;
      else begin
        m_stk[id][0] = v;
        m_cnt[id] = 1;
      end
    end else if (ps) begin
      if (c < m_depth[id]) begin
        m_stk[id][c] = v;
        m_cnt[id] = c + 1;
      end else oe = 1'b1;
    end else if (pp) begin
      if (c >= 1) m_cnt[id] = c - 1;
      else ue = 1'b1;
    end else if (sw) begin
      if (c >= 2) begin
        tmp = m_stk[id][c-1];
        m_stk[id][c-1] = m_stk[id][c-2];
        m_stk[id][c-2] = tmp;
      end else ue = 1'b1;
    end
    m_ovf[id] = oe | (m_ovf[id] & !clr);
    m_unf[id] = ue | (m_unf[id] & !clr);
  endtask

  task automatic drive(input int id, input bit ps, input bit pp, input bit sw,
                       input bit clr, input int unsigned v);
    bus0.push = 1'b0; bus0.pop = 1'b0; bus0.swap = 1'b0; bus0.clear_err = 1'b0; bus0.val = '0;
    bus1.push = 1'b0; bus1.pop = 1'b0; bus1.swap = 1'b0; bus1.clear_err = 1'b0; bus1.val = '0;
    if (id == 0) begin
      bus0.push = ps; bus0.pop = pp; bus0.swap = sw; bus0.clear_err = clr; bus0.val = 16'(v);
    end else if (id == 1) begin
      bus1.push = ps; bus1.pop = pp; bus1.swap = sw; bus1.clear_err = clr; bus1.val = 8'(v);
    end
  endtask

  task automatic step(input int id, input bit ps, input bit pp, input bit sw,
                      input bit clr, input int unsigned v, input string tag);
    @(negedge clk);
    drive(id, ps, pp, sw, clr, v);
    @(posedge clk);
    #1;
    drive(-1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    model_op(id, ps, pp, sw, clr, v);
    check_dut(id, tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_dut(0, {tag, ".d0"});
    check_dut(1, {tag, ".d1"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(-1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    model_reset();
    repeat (2) @(posedge clk);

    for (int id = 0; id < 2; id++) begin
      do_reset("rst");
      expect_eq("rst.empty", dut_flags(id), 32'h4);

      step(id, 1, 0, 0, 0, 32'h1111, "t1.p0");
      step(id, 1, 0, 0, 0, 32'h2222, "t1.p1");
      step(id, 1, 0, 0, 0, 32'h3333, "t1.p2");
      expect_eq("t1.count", dut_cnt(id), 32'd3);
      expect_eq("t1.top",   dut_top(id),  32'h3333 & m_mask[id]);
      expect_eq("t1.next",  dut_next(id), 32'h2222 & m_mask[id]);
      expect_eq("t1.flags", dut_flags(id), 32'h0);

      step(id, 1, 1, 0, 0, 32'hAAAA, "t2.repl");
      expect_eq("t2.top",   dut_top(id),  32'hAAAA & m_mask[id]);
      expect_eq("t2.count", dut_cnt(id),  32'd3);
      step(id, 0, 0, 1, 0, 0, "t2.swap");
      expect_eq("t2.stop",  dut_top(id),  32'h2222 & m_mask[id]);
      expect_eq("t2.snext", dut_next(id), 32'hAAAA & m_mask[id]);

      do_reset("t3.rst");
      for (int k = 0; k < m_depth[id]; k++) step(id, 1, 0, 0, 0, k, "t3.fill");
      step(id, 1, 0, 0, 0, 32'hBEEF, "t3.ovf");
      expect_eq("t3.count", dut_cnt(id),   32'(m_depth[id]));
      expect_eq("t3.top",   dut_top(id),   32'(m_depth[id] - 1));
      expect_eq("t3.flags", dut_flags(id), 32'hA);
      step(id, 0, 0, 0, 1, 0, "t3.clr");
      expect_eq("t3.clrfl", dut_flags(id), 32'h8);
      expect_eq("t3.clrtop", dut_top(id),  32'(m_depth[id] - 1));
      step(id, 1, 1, 0, 0, 32'h77, "t3.repl");
      expect_eq("t3.replfl", dut_flags(id), 32'h8);

      do_reset("t4.rst");
      step(id, 0, 1, 0, 0, 0, "t4.pop");
      expect_eq("t4.unf", dut_flags(id), 32'h5);
      step(id, 1, 1, 0, 0, 32'h5, "t4.pp");
      expect_eq("t4.top", dut_top(id), 32'h5);
      expect_eq("t4.cnt", dut_cnt(id), 32'd1);
      step(id, 0, 0, 1, 0, 0, "t4.swap");
      step(id, 0, 0, 1, 1, 0, "t4.swapclr");
      expect_eq("t4.win", dut_flags(id), 32'h1);
      step(id, 0, 0, 0, 1, 0, "t4.clr");

      step(id, 1, 0, 0, 0, 32'h9, "t5.push");
      step(id, 0, 1, 0, 0, 0, "t5.pop0");
      step(id, 0, 1, 0, 0, 0, "t5.pop1");
      expect_eq("t5.empty", dut_flags(id), 32'h4);
      for (int k = 0; k < 5; k++) step(id, 1, 0, 0, 0, 32'h40 + k, "t5.fill");
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      expect_eq("t5.async", dut_cnt(id), 32'd0);
      model_reset();
      check_dut(id, "t5.async");
      @(negedge clk);
      rst = 1'b1;
    end

    for (int id = 0; id < 2; id++) begin
      do_reset("rnd.rst");
      for (int n = 0; n < 300; n++) begin
        int r;
        bit ps, pp, sw, clr;
        r   = $urandom_range(0, 99);
        ps  = (r < 50);
        pp  = (r >= 40) && (r < 75);
        sw  = ((r >= 75) && (r < 90)) || ($urandom_range(0, 5) == 0);
        clr = ($urandom_range(0, 9) == 0);
        step(id, ps, pp, sw, clr, $urandom, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
